// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared timing constants for the 640x480 VGA output path, the sync window
// bounds derived from them, the update-arbiter state type and a small window
// decode helper used by the sync generators.
//
// Contents:
//   H_ACTIVE/H_FP/H_SYNC/H_BP/H_TOTAL   horizontal timing in pixels
//   V_ACTIVE/V_FP/V_SYNC/V_BP/V_TOTAL   vertical timing in lines
//   H_SYNC_START/H_SYNC_END             hcount window where Hsync is low
//   V_SYNC_START/V_SYNC_END             vcount window where Vsync is low
//   arb_state_e                         update arbiter states
//   in_window()                         inclusive range test on a counter
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 15;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 49;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 9;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 34;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  // Sync pulses start right after the front porch and last SYNC counts.
  localparam int H_SYNC_START = H_ACTIVE + H_FP;              // 655
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;    // 750
  localparam int V_SYNC_START = V_ACTIVE + V_FP;              // 489
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;    // 490

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    GRANT   = 2'd2,
    WAIT    = 2'd3
  } arb_state_e;

  // Inclusive window test on a 10-bit counter value.
  function automatic logic in_window(input logic [9:0] value,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_counter.sv
// -----------------------------------------------------------------------------
// vga_pixel_counter
//
// Horizontal/vertical pixel counter pair. hcount advances every pixel clock
// and wraps at the end of the line; on that wrap vcount advances and wraps at
// the end of the frame. Both counters clear on the synchronous reset.
//
// Ports:
//   clk          in   pixel clock
//   greset       in   synchronous active-high reset
//   hcount       out  10  horizontal position, 0..H_TOTAL-1
//   vcount       out  10  vertical position, 0..V_TOTAL-1
//   end_of_line  out  1   high while hcount is on the last pixel of a line
// -----------------------------------------------------------------------------
module vga_pixel_counter #(
  parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
  parameter int V_TOTAL = vga_timing_pkg::V_TOTAL
) (
  input  logic       clk,
  input  logic       greset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       end_of_line
);

  import vga_timing_pkg::*;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [9:0] hcount_r;
  logic [9:0] vcount_r;
  logic       eol_s;

  assign eol_s       = (hcount_r == H_LAST);
  assign hcount      = hcount_r;
  assign vcount      = vcount_r;
  assign end_of_line = eol_s;

  // Counter pair: hcount every cycle, vcount on each line wrap.
  always_ff @(posedge clk) begin
    if (greset) begin
      hcount_r <= 10'd0;
      vcount_r <= 10'd0;
    end else if (eol_s) begin
      hcount_r <= 10'd0;
      if (vcount_r == V_LAST) begin
        vcount_r <= 10'd0;
      end else begin
        vcount_r <= vcount_r + 10'd1;
      end
    end else begin
      hcount_r <= hcount_r + 10'd1;
    end
  end

endmodule

// File: rtl/vga_frame_sequencer.sv
// -----------------------------------------------------------------------------
// vga_frame_sequencer
//
// Sequences the VGA output path on the pixel clock: steps the pixel counters,
// generates registered active-low Hsync/Vsync, blanks the colour outside the
// visible region, and grants game logic a single update slot per request at
// the start of vertical blanking.
//
// Ports:
//   clk         in   pixel clock, single domain
//   greset      in   synchronous active-high reset
//   rgb_in      in   12  {R,G,B} colour for the current hcount/vcount
//   upd_req     in   1   update request, held high until granted
//   hcount      out  10  horizontal counter (unregistered)
//   vcount      out  10  vertical counter (unregistered)
//   active      out  1   hcount/vcount inside the visible region
//   frame_tick  out  1   pulse at (hcount=0, vcount=V_ACTIVE)
//   upd_grant   out  1   one-cycle grant, coincident with frame_tick
//   Hsync       out  1   registered horizontal sync, active-low
//   Vsync       out  1   registered vertical sync, active-low
//   vgaRed      out  4   registered, blanked red
//   vgaGreen    out  4   registered, blanked green
//   vgaBlue     out  4   registered, blanked blue
// -----------------------------------------------------------------------------
module vga_frame_sequencer #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic        clk,
  input  logic        greset,
  input  logic [11:0] rgb_in,
  input  logic        upd_req,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        active,
  output logic        frame_tick,
  output logic        upd_grant,
  output logic        Hsync,
  output logic        Vsync,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue
);

  import vga_timing_pkg::*;

  localparam int LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO      = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI      = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO      = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI      = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  // Last line before blanking; its final pixel is the grant decision point.
  localparam logic [9:0] V_PRE_BLANK = 10'(V_ACTIVE - 1);

  logic [9:0]  hcount_s;
  logic [9:0]  vcount_s;
  logic        eol_s;
  logic        active_s;
  logic        blank_start_s;
  logic        grant_point_s;

  arb_state_e  state_r;
  arb_state_e  state_nxt_s;
  logic        upd_grant_r;
  logic        hsync_r;
  logic        vsync_r;
  logic [11:0] rgb_r;

  vga_pixel_counter #(
    .H_TOTAL (LINE_TOTAL),
    .V_TOTAL (FRAME_LINES)
  ) u_pixel_counter (
    .clk         (clk),
    .greset      (greset),
    .hcount      (hcount_s),
    .vcount      (vcount_s),
    .end_of_line (eol_s)
  );

  assign active_s      = (hcount_s < H_VIS) && (vcount_s < V_VIS);
  assign blank_start_s = (hcount_s == 10'd0) && (vcount_s == V_VIS);
  // The counters step to (0, V_ACTIVE) on the next edge: deciding here lets
  // the registered grant line up with frame_tick.
  assign grant_point_s = eol_s && (vcount_s == V_PRE_BLANK);

  // Update arbiter next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (upd_req) begin
          state_nxt_s = PENDING;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PENDING: begin
        // A withdrawn request is dropped, even at the grant point.
        if (!upd_req) begin
          state_nxt_s = IDLE;
        end else if (grant_point_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = PENDING;
        end
      end
      GRANT: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        // Hold until the requester lets go so a stuck request is not
        // granted again next frame.
        if (!upd_req) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Arbiter state and registered grant.
  always_ff @(posedge clk) begin
    if (greset) begin
      state_r     <= IDLE;
      upd_grant_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      upd_grant_r <= (state_nxt_s == GRANT);
    end
  end

  // Output pipeline: sync decode and colour blanking, one stage behind the
  // counters.
  always_ff @(posedge clk) begin
    if (greset) begin
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
      rgb_r   <= 12'h000;
    end else begin
      hsync_r <= ~in_window(hcount_s, HS_LO, HS_HI);
      vsync_r <= ~in_window(vcount_s, VS_LO, VS_HI);
      rgb_r   <= active_s ? rgb_in : 12'h000;
    end
  end

  assign hcount     = hcount_s;
  assign vcount     = vcount_s;
  assign active     = active_s;
  assign frame_tick = blank_start_s;
  assign upd_grant  = upd_grant_r;
  assign Hsync      = hsync_r;
  assign Vsync      = vsync_r;
  assign vgaRed     = rgb_r[11:8];
  assign vgaGreen   = rgb_r[7:4];
  assign vgaBlue    = rgb_r[3:0];

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_sequencer
//
// Two instances share the clock: one at the real 640x480 timing for the
// first lines after reset (table of spot vectors plus sync pulse counting),
// and one with shrunken timing so whole frames and the update handshake can
// be exercised quickly against a position/time based reference model.
// -----------------------------------------------------------------------------
module tb_vga_frame_sequencer;

  // Shrunken timing for the fast instance.
  localparam int SH_A = 16, SH_FP = 3, SH_S = 4, SH_BP = 5;
  localparam int SV_A = 12, SV_FP = 2, SV_S = 2, SV_BP = 3;
  localparam int SHT = SH_A + SH_FP + SH_S + SH_BP;   // 28
  localparam int SVT = SV_A + SV_FP + SV_S + SV_BP;   // 19
  localparam int SFRAME = SHT * SVT;                  // 532
  localparam int SHS_LO = SH_A + SH_FP, SHS_HI = SH_A + SH_FP + SH_S - 1;
  localparam int SVS_LO = SV_A + SV_FP, SVS_HI = SV_A + SV_FP + SV_S - 1;

  logic clk;

  // Full-timing instance signals.
  logic        b_greset, b_req;
  logic [11:0] b_rgb;
  logic [9:0]  b_hcount, b_vcount;
  logic        b_active, b_ft, b_grant, b_hs, b_vs;
  logic [3:0]  b_r, b_g, b_b;

  // Shrunken-timing instance signals.
  logic        s_greset, s_req;
  logic [11:0] s_rgb;
  logic [9:0]  s_hcount, s_vcount;
  logic        s_active, s_ft, s_grant, s_hs, s_vs;
  logic [3:0]  s_r, s_g, s_b;

  vga_frame_sequencer u_big (
    .clk(clk), .greset(b_greset), .rgb_in(b_rgb), .upd_req(b_req),
    .hcount(b_hcount), .vcount(b_vcount), .active(b_active),
    .frame_tick(b_ft), .upd_grant(b_grant), .Hsync(b_hs), .Vsync(b_vs),
    .vgaRed(b_r), .vgaGreen(b_g), .vgaBlue(b_b)
  );

  vga_frame_sequencer #(
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
  ) u_small (
    .clk(clk), .greset(s_greset), .rgb_in(s_rgb), .upd_req(s_req),
    .hcount(s_hcount), .vcount(s_vcount), .active(s_active),
    .frame_tick(s_ft), .upd_grant(s_grant), .Hsync(s_hs), .Vsync(s_vs),
    .vgaRed(s_r), .vgaGreen(s_g), .vgaBlue(s_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Spot vectors for the full-timing instance, indexed by cycles since
  // reset release (cycle 0 is the first cycle with greset low).
  typedef struct {
    int cyc;
    int h;
    int v;
    int hs;
    int act;
    int rgb;
  } vec_t;
  vec_t tbl [12];

  // Reference model state for the shrunken instance: t is the number of
  // cycles since reset, so the screen position is plain div/mod of t.
  int          t;
  bit          model_valid = 1'b0;
  bit          prev_req_ok;
  bit          granted;
  bit          exp_hs, exp_vs, exp_grant;
  logic [11:0] exp_rgb;
  bit          grant_seen;

  function automatic bit at_pos(input int th, input int tv);
    return ((t % SHT) == th) && (((t / SHT) % SVT) == tv);
  endfunction

  // One cycle of the shrunken instance: check the cycle on screen now,
  // apply this cycle's inputs, then advance the model.
  task automatic tick(input bit rst, input bit req, input logic [11:0] rgb);
    int h, v, nh, nv;
    @(negedge clk);
    h = t % SHT;
    v = (t / SHT) % SVT;
    if (model_valid) begin
      check("hcount", int'(s_hcount), h);
      check("vcount", int'(s_vcount), v);
      check("active", int'(s_active), int'(h < SH_A && v < SV_A));
      check("frame_tick", int'(s_ft), int'(h == 0 && v == SV_A));
      check("Hsync", int'(s_hs), int'(exp_hs));
      check("Vsync", int'(s_vs), int'(exp_vs));
      check("rgb", int'({s_r, s_g, s_b}), int'(exp_rgb));
      check("upd_grant", int'(s_grant), int'(exp_grant));
    end
    grant_seen = s_grant;
    s_greset = rst;
    s_req    = req;
    s_rgb    = rgb;
    if (rst) begin
      t = 0;
      exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 12'h000; exp_grant = 1'b0;
      prev_req_ok = 1'b0; granted = 1'b0; model_valid = 1'b1;
    end else begin
      exp_hs  = !(h >= SHS_LO && h <= SHS_HI);
      exp_vs  = !(v >= SVS_LO && v <= SVS_HI);
      exp_rgb = (h < SH_A && v < SV_A) ? rgb : 12'h000;
      t = t + 1;
      nh = t % SHT;
      nv = (t / SHT) % SVT;
      // A request held for at least one earlier cycle is granted once at
      // the start of blanking; releasing it re-arms.
      exp_grant = req && prev_req_ok && !granted && nh == 0 && nv == SV_A;
      if (exp_grant) granted = 1'b1;
      if (!req) granted = 1'b0;
      prev_req_ok = req;
    end
  endtask

  task automatic run_to(input int th, input int tv, input bit req);
    int guard = 0;
    while (!at_pos(th, tv) && guard < SFRAME + 2) begin
      tick(1'b0, req, 12'($urandom));
      guard++;
    end
  endtask

  initial begin
    int first_fall, low_cnt, cnt, first_n;
    bit hs_prev;

    tbl[0]  = '{0,   0,   0, 1, 1, 12'h000};
    tbl[1]  = '{1,   1,   0, 1, 1, 12'hFFF};
    tbl[2]  = '{639, 639, 0, 1, 1, 12'hFFF};
    tbl[3]  = '{640, 640, 0, 1, 0, 12'hFFF};
    tbl[4]  = '{641, 641, 0, 1, 0, 12'h000};
    tbl[5]  = '{655, 655, 0, 1, 0, 12'h000};
    tbl[6]  = '{656, 656, 0, 0, 0, 12'h000};
    tbl[7]  = '{751, 751, 0, 0, 0, 12'h000};
    tbl[8]  = '{752, 752, 0, 1, 0, 12'h000};
    tbl[9]  = '{799, 799, 0, 1, 0, 12'h000};
    tbl[10] = '{800, 0,   1, 1, 1, 12'h000};
    tbl[11] = '{801, 1,   1, 1, 1, 12'hFFF};

    s_greset = 1'b1; s_req = 1'b0; s_rgb = 12'h000; t = 0;
    b_greset = 1'b1; b_req = 1'b0; b_rgb = 12'hFFF;

    // ---------------- full-timing instance: first two lines -------------
    repeat (2) @(negedge clk);
    first_fall = -1; low_cnt = 0; hs_prev = 1'b1;
    for (int k = 0; k <= 1700; k++) begin
      if (k > 0) @(negedge clk);
      b_greset = 1'b0;
      if (!b_hs && hs_prev && first_fall < 0) first_fall = k;
      if (k < 1600 && !b_hs) low_cnt++;
      hs_prev = b_hs;
      if (k % 100 == 0) begin
        check("big_vsync_high", int'(b_vs), 1);
        check("big_no_grant", int'(b_grant), 0);
      end
      for (int i = 0; i < 12; i++) begin
        if (tbl[i].cyc == k) begin
          check("tbl_hcount", int'(b_hcount), tbl[i].h);
          check("tbl_vcount", int'(b_vcount), tbl[i].v);
          check("tbl_Hsync", int'(b_hs), tbl[i].hs);
          check("tbl_active", int'(b_active), tbl[i].act);
          check("tbl_rgb", int'({b_r, b_g, b_b}), tbl[i].rgb);
        end
      end
    end
    check("big_first_hsync_fall", first_fall, 656);
    check("big_hsync_low_2lines", low_cnt, 192);

    // ---------------- shrunken instance ----------------------------------
    tick(1'b1, 1'b0, 12'h000);
    tick(1'b1, 1'b0, 12'h000);
    repeat (3) tick(1'b0, 1'b0, 12'hFFF);

    // Request mid-frame: exactly one grant at this frame's blanking start,
    // none while the request stays high through the next frame.
    run_to(5, 2, 1'b0);
    tick(1'b0, 1'b1, 12'hFFF);
    cnt = 0; first_n = -1;
    for (int n = 1; n <= 2 * SFRAME; n++) begin
      tick(1'b0, 1'b1, 12'hFFF);
      if (grant_seen) begin
        cnt++;
        if (first_n < 0) first_n = n;
      end
    end
    check("seqA_grant_count", cnt, 1);
    check("seqA_grant_latency", first_n, (SV_A - 2) * SHT - 5);
    repeat (4) tick(1'b0, 1'b0, 12'($urandom));

    // Request just after the grant point: served next frame.
    run_to(5, SV_A, 1'b0);
    tick(1'b0, 1'b1, 12'($urandom));
    cnt = 0; first_n = -1;
    for (int n = 1; n <= 2 * SFRAME; n++) begin
      tick(1'b0, 1'b1, 12'($urandom));
      if (grant_seen) begin
        cnt++;
        if (first_n < 0) first_n = n;
      end
    end
    check("seqB_grant_latency", first_n, SFRAME - 5);
    check("seqB_grant_count", cnt, 1);
    repeat (4) tick(1'b0, 1'b0, 12'($urandom));

    // Request withdrawn before blanking: no grant.
    run_to(5, 2, 1'b0);
    tick(1'b0, 1'b1, 12'($urandom));
    run_to(5, 6, 1'b1);
    cnt = 0;
    for (int n = 0; n < SFRAME; n++) begin
      tick(1'b0, 1'b0, 12'($urandom));
      if (grant_seen) cnt++;
    end
    check("seqC_no_grant", cnt, 0);

    // Reset inside the Vsync window while pending.
    run_to(5, SV_A + 1, 1'b0);
    tick(1'b0, 1'b1, 12'hFFF);
    run_to(20, SV_A + SV_FP, 1'b1);
    tick(1'b1, 1'b1, 12'hFFF);
    tick(1'b0, 1'b0, 12'hFFF);
    check("seqD_hcount", int'(s_hcount), 0);
    check("seqD_vcount", int'(s_vcount), 0);
    check("seqD_Hsync", int'(s_hs), 1);
    check("seqD_Vsync", int'(s_vs), 1);
    check("seqD_rgb", int'({s_r, s_g, s_b}), 0);
    cnt = 0;
    for (int n = 0; n < SFRAME; n++) begin
      tick(1'b0, 1'b0, 12'hFFF);
      if (grant_seen) cnt++;
    end
    check("seqD_no_grant", cnt, 0);

    // Random traffic: request level changes on 8-cycle boundaries, random
    // colour every cycle, rare resets.
    for (int blk = 0; blk < (12 * SFRAME) / 8; blk++) begin
      bit req_lvl;
      req_lvl = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < 8; c++) begin
        tick(($urandom_range(0, 1999) == 0), req_lvl, 12'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
